// File: rtl/panel_key_ctrl_if.sv
// Handshake between the panel key controller and the manual timing generator,
// together with the function bus the controller hands to the transfer logic.
interface panel_key_ctrl_if;
  logic       mfts_go;
  logic       mftp0;
  logic       mftp1;
  logic       mftp2;
  logic [2:0] fn;
  logic       fn_p0;
  logic       fn_p1;
  logic       fn_p2;
  logic       run_set;

  // Key controller side: drives the start level and function bus, receives pulses.
  modport master (
    output mfts_go, fn, fn_p0, fn_p1, fn_p2, run_set,
    input  mftp0, mftp1, mftp2
  );

  // Generator / consumer side.
  modport slave (
    input  mfts_go, fn, fn_p0, fn_p1, fn_p2, run_set,
    output mftp0, mftp1, mftp2
  );
endinterface

// File: rtl/panel_key_ctrl.sv
// Front-panel key controller: synchronises and debounces the console keys,
// picks one manual function, holds mfts_go while the timing generator runs
// and turns its three timing pulses into one-cycle function strobes.
module panel_key_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLDOFF_CYCLES  = 32,
  parameter int GO_TIMEOUT      = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_load_add,
  input  logic             key_dep,
  input  logic             key_exam,
  input  logic             key_cont,
  input  logic             key_stop,
  input  logic             run,
  panel_key_ctrl_if.master gen,
  output logic             stop_req,
  output logic             fault
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam int TO_W = $clog2(GO_TIMEOUT + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(GO_TIMEOUT - 1);
  localparam int K_STOP = 5;

  localparam logic [2:0] FN_NONE     = 3'd0;
  localparam logic [2:0] FN_START    = 3'd1;
  localparam logic [2:0] FN_LOAD_ADD = 3'd2;
  localparam logic [2:0] FN_DEP      = 3'd3;
  localparam logic [2:0] FN_EXAM     = 3'd4;
  localparam logic [2:0] FN_CONT     = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_HOLDOFF = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Key vector, bit 0 = START ... bit 5 = STOP
  logic [5:0]      key_raw_s;
  logic [5:0]      sync1_r;
  logic [5:0]      sync2_r;
  logic [5:0]      deb_r;
  logic [5:0]      press_r;
  logic [DB_W-1:0] db_cnt_r [6];

  state_t          state_r;
  logic            go_r;
  logic [2:0]      fn_r;
  logic            fn_p0_r;
  logic            fn_p1_r;
  logic            fn_p2_r;
  logic            run_set_r;
  logic            fault_r;
  logic            seen_p0_r;
  logic [TO_W-1:0] tmo_r;
  logic [HO_W-1:0] ho_r;
  logic [2:0]      mftp_prev_r;

  logic [2:0]      mftp_s;
  logic [2:0]      mftp_rise_s;
  logic            mftp2_fall_s;
  logic [2:0]      sel_fn_s;

  assign key_raw_s    = {key_stop, key_cont, key_exam, key_dep, key_load_add, key_start};
  assign mftp_s       = {gen.mftp2, gen.mftp1, gen.mftp0};
  assign mftp_rise_s  = mftp_s & ~mftp_prev_r;
  assign mftp2_fall_s = ~mftp_s[2] & mftp_prev_r[2];

  assign gen.mfts_go  = go_r;
  assign gen.fn       = fn_r;
  assign gen.fn_p0    = fn_p0_r;
  assign gen.fn_p1    = fn_p1_r;
  assign gen.fn_p2    = fn_p2_r;
  assign gen.run_set  = run_set_r;
  assign stop_req     = press_r[K_STOP];
  assign fault        = fault_r;

  // Two-flop synchroniser for the asynchronous raw keys
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 6'b000000;
      sync2_r <= 6'b000000;
    end else begin
      sync1_r <= key_raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Per-key stability counter; the debounced state flips after a full run of
  // disagreement and a one-cycle press pulse marks each debounced rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_r   <= 6'b000000;
      press_r <= 6'b000000;
      for (int i = 0; i < 6; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          db_cnt_r[i] <= '0;
          press_r[i]  <= 1'b0;
        end else if (db_cnt_r[i] >= DB_LAST) begin
          deb_r[i]    <= sync2_r[i];
          db_cnt_r[i] <= '0;
          press_r[i]  <= sync2_r[i];
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
          press_r[i]  <= 1'b0;
        end
      end
    end
  end

  // Fixed-priority pick among this cycle's press events (STOP excluded)
  always_comb begin
    sel_fn_s = FN_NONE;
    if (press_r[0]) begin
      sel_fn_s = FN_START;
    end else if (press_r[1]) begin
      sel_fn_s = FN_LOAD_ADD;
    end else if (press_r[2]) begin
      sel_fn_s = FN_DEP;
    end else if (press_r[3]) begin
      sel_fn_s = FN_EXAM;
    end else if (press_r[4]) begin
      sel_fn_s = FN_CONT;
    end else begin
      sel_fn_s = FN_NONE;
    end
  end

  // Operation sequencer; strobes are registered, so each follows the sampled
  // pulse edge by one cycle and run_set lines up exactly with fn_p2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_RELEASE;
      go_r        <= 1'b0;
      fn_r        <= FN_NONE;
      fn_p0_r     <= 1'b0;
      fn_p1_r     <= 1'b0;
      fn_p2_r     <= 1'b0;
      run_set_r   <= 1'b0;
      fault_r     <= 1'b0;
      seen_p0_r   <= 1'b0;
      tmo_r       <= '0;
      ho_r        <= '0;
      mftp_prev_r <= 3'b000;
    end else begin
      mftp_prev_r <= mftp_s;
      fn_p0_r     <= 1'b0;
      fn_p1_r     <= 1'b0;
      fn_p2_r     <= 1'b0;
      run_set_r   <= 1'b0;
      fault_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tmo_r     <= '0;
          ho_r      <= '0;
          seen_p0_r <= 1'b0;
          if ((sel_fn_s != FN_NONE) && !run) begin
            fn_r    <= sel_fn_s;
            go_r    <= 1'b1;
            state_r <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          fn_p0_r   <= mftp_rise_s[0];
          fn_p1_r   <= mftp_rise_s[1];
          fn_p2_r   <= mftp_rise_s[2];
          run_set_r <= mftp_rise_s[2] & ((fn_r == FN_START) | (fn_r == FN_CONT));
          if (mftp_rise_s[0]) begin
            seen_p0_r <= 1'b1;
          end
          if (mftp2_fall_s) begin
            go_r    <= 1'b0;
            fn_r    <= FN_NONE;
            ho_r    <= '0;
            state_r <= ST_HOLDOFF;
          end else if (!seen_p0_r && !mftp_rise_s[0]) begin
            if (tmo_r >= TO_LAST) begin
              // generator never answered: abandon the operation
              fault_r <= 1'b1;
              go_r    <= 1'b0;
              fn_r    <= FN_NONE;
              ho_r    <= '0;
              state_r <= ST_HOLDOFF;
            end else begin
              tmo_r <= tmo_r + TO_W'(1);
            end
          end else begin
            state_r <= ST_BUSY;
          end
        end
        ST_HOLDOFF: begin
          // keep mfts_go low long enough for the generator timer to clear
          if (ho_r >= HO_LAST) begin
            state_r <= ST_RELEASE;
          end else begin
            ho_r <= ho_r + HO_W'(1);
          end
        end
        ST_RELEASE: begin
          if (deb_r == 6'b000000) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_RELEASE;
          end
        end
        default: begin
          go_r    <= 1'b0;
          fn_r    <= FN_NONE;
          state_r <= ST_RELEASE;
        end
      endcase
    end
  end

endmodule

// File: doc/panel_key_ctrl.md
Name: panel_key_ctrl

Overview:
- Front-panel key controller that sits directly upstream of the manual timing generator.
- Synchronises and debounces the console keys, arbitrates them into a single manual function, and holds the manual-start level that launches the generator's three timing pulses.
- Consumes the returned timing pulses and issues one-cycle function strobes, which drive the register-transfer logic (SR→PC, deposit, examine, run control).

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a synchronised key must stay stable to change debounced state (10 ms at 100 MHz).
- HOLDOFF_CYCLES, 32, minimum low time of mfts_go between operations. Must exceed the generator's post-pulse tail (about 10 cycles).
- GO_TIMEOUT, 1024, cycles allowed from mfts_go rise to the first mftp0 before abort.

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  asynchronous reset, active-high
- key_start, key_load_add, key_dep, key_exam, key_cont, key_stop  in  1 each  raw panel keys, active-high, asynchronous, bouncy
- run  in  1  processor RUN flip-flop
- mftp0, mftp1, mftp2  in  1 each  timing pulses from manual timing generator (about 9 cycles wide each)
- mfts_go  out  1  manual start level to timing generator
- fn  out  3  latched function: 0 none, 1 START, 2 LOAD_ADD, 3 DEP, 4 EXAM, 5 CONT
- fn_p0, fn_p1, fn_p2  out  1 each  one-cycle strobes on rising edge of mftp0/1/2 while BUSY
- run_set  out  1  one-cycle pulse, START/CONT only, coincident with fn_p2
- stop_req  out  1  one-cycle pulse on debounced STOP press
- fault  out  1  one-cycle pulse on GO timeout

Behaviour:
- Reset (async) values:
  - all outputs 0
  - fn = 0
  - FSM = RELEASE
  - debounce counters 0
  - debounced key states 0
- Input conditioning:
  - Each key passes through a 2-FF synchroniser, then its own stability counter.
  - The debounced state toggles only after DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreement clears the counter.
  - Press events are rising edges of the debounced state.
  - Latency from a clean raw edge to the event is 2 + DEBOUNCE_CYCLES cycles (±1).
- STOP handling:
  - A STOP event pulses stop_req in any FSM state, including BUSY.
  - STOP never starts a timing sequence.
- Edge detection: registered previous value of mftp0/1/2. fn_pN = mftpN & ~prev & (state==BUSY).
- FSM states:
  - IDLE:
    - On any non-STOP press event with run=0, latch fn using priority START > LOAD_ADD > DEP > EXAM > CONT, assert mfts_go, and go to BUSY.
    - If run=1, events for keys other than STOP are discarded (stay IDLE).
    - Simultaneous events resolve by priority; losers are discarded.
  - BUSY:
    - mfts_go = 1; timeout counter runs.
    - First fn_p0 stops the counter.
    - On mftp2 falling edge: mfts_go = 0, fn = 0, go to HOLDOFF.
    - If the counter reaches GO_TIMEOUT with no mftp0 seen: pulse fault, mfts_go = 0, fn = 0, go to HOLDOFF.
    - Key events in BUSY are ignored (except stop_req).
    - run_set = fn_p2 & (fn==START | fn==CONT).
  - HOLDOFF:
    - mfts_go = 0 for exactly HOLDOFF_CYCLES cycles, then go to RELEASE.
    - This guarantees the generator's timer has returned to zero, so the next rise is seen.
  - RELEASE:
    - Wait until all six debounced keys read 0, then go to IDLE.
    - Enforces one operation per press; a key held through an operation never retriggers.
- fn is stable for the whole of BUSY and 0 elsewhere.
- mfts_go never glitches; it is a registered output.
- Reset mid-BUSY drops mfts_go immediately and asynchronously. After reset release, the FSM returns to RELEASE, and no strobes or run_set are produced for the interrupted operation.
- Debounce counter width: clog2(DEBOUNCE_CYCLES+1). Timeout and holdoff counters sized from their parameters; all counters saturate, never wrap.

Test Plan (sim with DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=32, GO_TIMEOUT=64, behavioural generator model):
- key_load_add clean press, run=0 → fn=2 and mfts_go rise 6–7 cycles after press; one each of fn_p0/fn_p1/fn_p2 at generator offsets 1/201/401; run_set stays 0; mfts_go falls after mftp2; fn=0.
- key_start press → fn=1; run_set is one cycle, coincident with fn_p2; key held 2000 cycles after completion → no second mfts_go rise; release then re-press → second sequence runs.
- key_dep and key_exam pressed in the same cycle → fn=3 only; exactly one sequence.
- Bounce: key_exam toggling every 2 cycles for 40 cycles, then stable high → exactly one event and one sequence.
- run=1, key_cont press → no mfts_go; key_stop press during BUSY → stop_req one cycle; sequence completes normally.
- Generator model mute → fault pulse 64 cycles after mfts_go rise, then 32-cycle holdoff. Separately, assert rst at BUSY +250 → mfts_go 0 the same cycle and no fn_p2.
